// File: rtl/pipeline_mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed DATA_WIDTH+1 cycle latency from acceptance to the done pulse, cancellable.
module pipeline_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]         b;       // multiplicand / divisor magnitude
  logic                 neg_res, neg_rem;

  logic           accept, last;
  logic           rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [W:0]     mul_sum, rem_sh, rem_diff;
  logic           rem_ge;
  logic [2*W-1:0] mul_nxt, div_nxt, prod;
  logic [W-1:0]   quo, rem, hi_fin, lo_fin;

  assign accept = start && !cancel && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_WIDTH'(W));
  assign busy   = (state == MUL) || (state == DIV);
  assign done   = (state == DONE);

  assign rs_neg = !op[0] && rs_data[W-1];
  assign rt_neg = !op[0] && rt_data[W-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // One shift-add step: add multiplicand into the upper half on LSB, then shift right.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : '0);
  assign mul_nxt = {mul_sum, acc[W-1:1]};

  // One restoring step: remainder stays below the divisor, so the difference fits W bits.
  assign rem_sh   = acc[2*W-1:W-1];
  assign rem_diff = rem_sh - {1'b0, b};
  assign rem_ge   = (rem_sh >= {1'b0, b});
  assign div_nxt  = rem_ge ? {rem_diff[W-1:0], acc[W-2:0], 1'b1}
                           : {rem_sh[W-1:0],   acc[W-2:0], 1'b0};

  // Divide by zero naturally leaves |dividend| as remainder; sign fix restores it.
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quo    = acc[W-1:0];
    rem    = acc[2*W-1:W];
    hi_fin = prod[2*W-1:W];
    lo_fin = prod[W-1:0];
    if (state == DIV) begin
      hi_fin = neg_rem ? -rem : rem;
      lo_fin = (b == '0) ? '1 : (neg_res ? -quo : quo);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) state_nxt = op[1] ? DIV : MUL;
      end
      MUL, DIV: begin
        if (cancel)    state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      b        <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      acc     <= {{W{1'b0}}, rs_mag};
      b       <= rt_mag;
      neg_res <= rs_neg ^ rt_neg;
      neg_rem <= rs_neg;
    end else if (busy && !cancel) begin
      if (last) begin
        hi       <= hi_fin;
        lo       <= lo_fin;
        div_zero <= (state == DIV) && (b == '0);
      end else begin
        acc <= (state == MUL) ? mul_nxt : div_nxt;
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_pipeline_mdu.sv
// Randomized bench for pipeline_mdu against a plain-arithmetic reference model,
// plus directed corner cases: overflow divide, divide by zero, cancel, async reset.
module tb_pipeline_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        cancel = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  pipeline_mdu #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data),
    .rt_data(rt_data), .cancel(cancel), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {div_zero, hi, lo}
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] d);
    longint sa, sd, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sd = longint'($signed(d));
    case (o)
      2'b00: begin p = sa * sd; return {1'b0, p[63:0]}; end
      2'b01: begin u = {32'b0, a} * {32'b0, d}; return {1'b0, u}; end
      2'b10: begin
        if (d == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sd;
        r = sa % sd;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (d == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % d, a / d};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                        input bit inject);
    logic [64:0] e;
    int n, busy_n;
    bit got;
    e = ref_model(o, a, d);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = d;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 5) begin
        start = 1'b1; op = 2'b01; rs_data = 32'h1234; rt_data = 32'h5;
      end
      if (inject && n == 6) start = 1'b0;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    chk("latency", 64'(n), 64'd33);
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
    chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
    chk("div_zero", {63'b0, div_zero}, {63'b0, e[64]});
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(posedge clk); #1;
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    chk("hold_hi", {32'b0, hi}, {32'b0, exp_hi});
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int dn;

    #2;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_dz", {63'b0, div_zero}, 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, -32'sd3, 32'd7, 1'b0);
    run_op(2'b10, -32'sd7, 32'd2, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b10, -32'sd9, 32'd0, 1'b0);

    // cancel ten cycles into a MULT
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'b0, busy}, 64'd0);
    chk("cancel_done", {63'b0, done}, 64'd0);
    chk("cancel_hi", {32'b0, hi}, {32'b0, exp_hi});
    chk("cancel_lo", {32'b0, lo}, {32'b0, exp_lo});
    run_op(2'b00, -32'sd5, -32'sd6, 1'b0);

    // async reset five cycles into a DIVU
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_hi", {32'b0, hi}, 64'd0);
    chk("arst_lo", {32'b0, lo}, 64'd0);
    chk("arst_dz", {63'b0, div_zero}, 64'd0);
    @(negedge clk); rst = 1'b1;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    chk("arst_no_done", 64'(dn), 64'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
